// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared widths, length limit and FSM state type for the BRAM stream reader
package bram_stream_reader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 11;
    localparam int MAX_LEN    = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bram_stream_reader_skid_fifo2.sv
// rtl/bram_stream_reader_skid_fifo2.sv - two-entry prefetch FIFO with occupancy, registered head
module skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic         head_valid_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;

    // Occupancy follows push and pop; the caller never pushes into a full FIFO
    always_comb begin
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    // Storage and pointers; entries are cleared so the head reads 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_data_o  = mem_q[rd_ptr_q];
    assign head_valid_o = (cnt_q != 2'd0);
    assign occ_o        = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - command-driven BRAM port-B byte streamer; BRAM_RDR_CHECKSUM_EN appends a checksum beat
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_last_q, rd_last_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_last;
    logic              fifo_valid;
    logic [1:0]        fifo_occ;
    logic              fifo_pop;

    logic [LEN_W-1:0]  len_clamped;
    logic [LEN_W-1:0]  total_beats;
    logic [2:0]        inflight;
    logic              accept;
    logic              issue;
    logic              issue_last;
    logic              beat_pop;
    logic              final_beat;

    assign accept      = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign fifo_pop    = fifo_valid && m_ready;
    assign beat_pop    = m_valid && m_ready;

    // Buffered bytes plus the read in flight, less the byte leaving this cycle,
    // must stay below two so the capture never finds the FIFO full.
    assign inflight    = 3'(fifo_occ) + 3'(rd_pend_q) - 3'(fifo_pop);
    assign issue       = (state_q == ST_FETCH) && (inflight < 3'd2);
    assign issue_last  = (issue_cnt_q == len_q - LEN_W'(1));
    assign final_beat  = beat_pop && (beat_cnt_q == total_beats - LEN_W'(1));

    skid_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (rd_pend_q),
        .push_data_i  ({rd_last_q, bram_dout}),
        .pop_i        (fifo_pop),
        .head_data_o  ({fifo_last, fifo_data}),
        .head_valid_o (fifo_valid),
        .occ_o        (fifo_occ)
    );

`ifdef BRAM_RDR_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              csum_valid_q, csum_valid_d;

    assign total_beats = len_q + LEN_W'(1);
    assign m_valid     = fifo_valid || csum_valid_q;
    assign m_data      = csum_valid_q ? (~sum_q + DATA_W'(1)) : fifo_data;
    assign m_last      = csum_valid_q;

    // Running sum of data beats; the checksum beat is armed once the last data byte leaves
    always_comb begin
        sum_d        = sum_q;
        csum_valid_d = csum_valid_q;
        if (accept) begin
            sum_d        = '0;
            csum_valid_d = (len_clamped == '0);
        end else begin
            if (fifo_pop) begin
                sum_d = sum_q + fifo_data;
                if (fifo_last) begin
                    csum_valid_d = 1'b1;
                end
            end
            if (csum_valid_q && m_ready) begin
                csum_valid_d = 1'b0;
            end
        end
    end

    // Checksum state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q        <= '0;
            csum_valid_q <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            csum_valid_q <= csum_valid_d;
        end
    end
`else
    assign total_beats = len_q;
    assign m_valid     = fifo_valid;
    assign m_data      = fifo_data;
    assign m_last      = fifo_valid && fifo_last;
`endif

    // Next state, read issue, address generation and beat counting
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        bram_addr_d = bram_addr_q;
        rd_pend_d   = issue;
        rd_last_d   = issue && issue_last;

        if (beat_pop) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d       = len_clamped;
                    bram_addr_d = cmd_addr;
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                    if (len_clamped == '0) begin
`ifdef BRAM_RDR_CHECKSUM_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    bram_addr_d = bram_addr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q + LEN_W'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (final_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Control registers; reset abandons any stream in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            bram_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            bram_addr_q <= bram_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign bram_addr = bram_addr_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Streaming read engine for the 1K x 8 dual-port block RAM. It owns port B of the RAM and turns one command (start address, byte count) into a valid/ready byte stream with full backpressure. It sits between the RAM and downstream packet/serial logic; port A remains with the writer. Sustains one byte per cycle while the sink holds `m_ready` high.

## Interface
- `ADDR_W`, 10, RAM address width (1024 bytes)
- `DATA_W`, 8, RAM/stream data width
- `LEN_W`, 11, command length width (0..1024 bytes)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  LEN_W  byte count; values above 1024 are clamped to 1024
- `bram_addr`  out  ADDR_W  to RAM `addr_b`, registered; RAM `wr_b` tied 0 by parent
- `bram_dout`  in  DATA_W  from RAM `dataout_b`, one-cycle read latency
- `m_data`  out  DATA_W  stream byte
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  sink ready
- `m_last`  out  1  qualifies final beat
- `busy`  out  1  high from command accept until last beat accepted
- `done`  out  1  one-cycle pulse after the final beat is accepted (or after a zero-length command)

## Operation
- Reset values: `cmd_ready`=0 during reset and 1 in IDLE after reset; `bram_addr`=0, `m_data`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0.
- States: IDLE -> FETCH on `cmd_valid & cmd_ready`. FETCH -> DRAIN when all reads have been issued. DRAIN -> DONE when the final beat handshakes. DONE -> IDLE unconditionally after one cycle (`done`=1).
- Zero-length command: IDLE -> DONE directly. No beats are produced.
- Counters:
  - `issue_cnt` counts reads issued.
  - `beat_cnt` counts beats accepted, LEN_W bits.
  - The address increments modulo 1024; start 1020, length 8 reads 1020..1023, 0..3.
- Prefetch buffer: 2-entry skid FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2.
  - This guarantees no overflow under arbitrary `m_ready`.
- In-flight tracking: the RAM reads every cycle, so a 1-bit `rd_pend` register marks the cycle whose `bram_dout` is captured.
- `m_last` = `m_valid` & (head entry is byte number `len`-1).
- Reader never writes the RAM.
- Port A write to the address being read in the same cycle: the reader returns the old byte (RAM read-first behaviour). Software must not rewrite a region being streamed.
- `cmd_valid` while busy is ignored (`cmd_ready`=0). No queueing and no abort.
- `rst_n` asserted mid-stream clears everything immediately. The beat in progress is lost and no `done` pulse is produced.

## Timing
- Command accepted at edge T. `bram_addr` = start in cycle T+1. Byte captured at edge ending T+2. First `m_valid` in cycle T+3.
- First-beat latency: 3 cycles.
- With `m_ready` held 1: one beat per cycle; N bytes finish with the last beat in cycle T+2+N and `done` in cycle T+3+N.
- `m_data`/`m_last` stay stable while `m_valid & !m_ready`.
- `m_valid` never depends combinationally on `m_ready`.
- `cmd_ready` returns high in the cycle after `done`.

## Configuration
- `BRAM_RDR_CHECKSUM_EN` defined:
  - Keeps an 8-bit modulo-256 sum of all data beats.
  - Appends the two's complement of that sum as one extra beat after the data. That beat carries `m_last`; data beats do not.
  - Zero-length commands emit a single checksum beat of 0x00.
  - `done` follows the checksum beat.
- `BRAM_RDR_CHECKSUM_EN` undefined: no checksum logic and no extra beat; behaviour as above.

## Structure
- Shared package: `ADDR_W`/`DATA_W`/`LEN_W` defaults, the state enum (IDLE, FETCH, DRAIN, DONE), and the `MAX_LEN` = 1024 constant.
- One sub-module, `skid_fifo2`: 2-entry, DATA_W+1 wide (data + last flag), with occupancy output. Top level holds the FSM, counters and address generation.

## Test plan
- Preload RAM 0x000..0x3FF with addr[7:0]; cmd addr 0x010, len 4, `m_ready`=1 -> bytes 0x10,0x11,0x12,0x13 in cycles T+3..T+6, `m_last` on 0x13, `done` at T+7.
- Start 0x3FE, len 4 -> 0xFE,0xFF,0x00,0x01 (address wrap).
- Len 16 with `m_ready` toggled randomly -> all 16 bytes in order, none dropped or duplicated, data held stable while stalled.
- Len 0 -> no `m_valid`, `done` pulse one cycle after accept; with checksum macro, single beat 0x00 with `m_last`.
- `rst_n` low during beat 5 of 10 -> all outputs at reset values immediately; a new cmd after release streams correctly from its start address.
- With `BRAM_RDR_CHECKSUM_EN`, bytes 0x01,0x02,0x03 -> extra beat 0xFA with `m_last`.
